// File: rtl/word_com_p_if.sv
// Letter-in / beat-out handshake bundle between the tokenizer, the word combiner and key_comp.
// slave is the combiner side; master is the upstream/downstream side that drives letters and ready.
interface word_com_p_if #(
  parameter int unsigned LETTER_W = 8,
  parameter int unsigned OUT_W    = 32
);
  logic                data_in;
  logic [LETTER_W-1:0] letter_in;
  logic                flush;
  logic                out_ready;
  logic                out_valid;
  logic [OUT_W-1:0]    out_data;
  logic                out_last;

  modport master (
    output data_in, letter_in, flush, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  data_in, letter_in, flush, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/word_com_p.sv
// Letter-to-word combiner: packs letters into WORD_W-bit words, buffers them in a FIFO and
// streams each word out as BEATS handshaked OUT_W-bit beats, low beat first.
//
// state  | meaning
// O_IDLE | no word in the shift register; pops the FIFO head when one is stored
// O_SEND | presenting beat `beat_q` of the current word, advancing on out_ready
module word_com_p #(
  parameter int unsigned         LETTER_W     = 8,
  parameter int unsigned         WORD_LETTERS = 16,
  parameter int unsigned         DEPTH        = 64,
  parameter int unsigned         OUT_W        = 32,
  parameter logic [LETTER_W-1:0] DELIM        = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  word_com_p_if.slave            bus,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic [15:0]            word_count_o,
  output logic                   overflow_o
);
  localparam int unsigned WORD_W = LETTER_W * WORD_LETTERS;
  localparam int unsigned BEATS  = WORD_W / OUT_W;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PTR_W  = $clog2(WORD_LETTERS + 1);
  localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(WORD_LETTERS);
  localparam logic [AW:0]      LVL_FULL  = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0]    BEAT_LAST = BW'(BEATS - 1);

  typedef enum logic {O_IDLE, O_SEND} ostate_e;

  logic [WORD_W-1:0] buf_q, buf_d, word_n;
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_n;
  logic              close, push, drop, pop;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       level_q;
  logic [15:0]       word_count_q;
  logic              overflow_q;

  ostate_e           state_q;
  logic [WORD_W-1:0] shift_q;
  logic [BW-1:0]     beat_q, beat_n;
  logic              out_valid_q, out_last_q;
  logic [OUT_W-1:0]  out_data_q;

  // The letter of this cycle lands in word_n first, so flush and full-word closes include it.
  always_comb begin
    word_n = buf_q;
    ptr_n  = ptr_q;
    close  = 1'b0;
    if (bus.data_in) begin
      if (bus.letter_in != DELIM) begin
        word_n[ptr_q*LETTER_W +: LETTER_W] = bus.letter_in;
        ptr_n = ptr_q + 1'b1;
        close = (ptr_n == PTR_FULL);
      end else begin
        close = (ptr_q != '0);
      end
    end
    if (bus.flush && (ptr_n != '0)) close = 1'b1;
    buf_d = close ? '0 : word_n;
    ptr_d = close ? '0 : ptr_n;
  end

  // Fullness is judged on the level before the edge; a same-edge pop cannot make room.
  assign push   = close && (level_q != LVL_FULL);
  assign drop   = close && (level_q == LVL_FULL);
  assign pop    = (state_q == O_IDLE) && (level_q != '0);
  assign beat_n = beat_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= word_n;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      buf_q        <= '0;
      ptr_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      state_q      <= O_IDLE;
      shift_q      <= '0;
      beat_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      buf_q <= buf_d;
      ptr_q <= ptr_d;
      if (push) begin
        wr_q         <= wr_q + 1'b1;
        word_count_q <= word_count_q + 1'b1;
      end
      if (drop) overflow_q <= 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;

      case (state_q)
        O_IDLE: begin
          if (pop) begin
            shift_q     <= mem_q[rd_q];
            out_data_q  <= mem_q[rd_q][OUT_W-1:0];
            out_last_q  <= (BEATS == 1);
            out_valid_q <= 1'b1;
            beat_q      <= '0;
            state_q     <= O_SEND;
          end
        end
        O_SEND: begin
          if (bus.out_ready) begin
            if (beat_q == BEAT_LAST) begin
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              state_q     <= O_IDLE;
            end else begin
              beat_q     <= beat_n;
              out_data_q <= shift_q[beat_n*OUT_W +: OUT_W];
              out_last_q <= (beat_n == BEAT_LAST);
            end
          end
        end
        default: state_q <= O_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign fifo_level_o  = level_q;
  assign word_count_o  = word_count_q;
  assign overflow_o    = overflow_q;
endmodule

// File: tb/tb_word_com_p.sv
// Bench for word_com_p: letter-list reference model feeds a beat scoreboard that a
// negedge monitor drains on every accepted beat; directed scenarios plus a random phase.
module tb_word_com_p;
  localparam int LW = 8, WL = 16, DEPTH = 64, OW = 32, BEATS = 4;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_com_p_if #(.LETTER_W(LW), .OUT_W(OW)) bus ();
  logic [6:0]  fifo_level;
  logic [15:0] word_count;
  logic        overflow;

  word_com_p #(
    .LETTER_W(LW), .WORD_LETTERS(WL), .DEPTH(DEPTH), .OUT_W(OW), .DELIM(8'h00)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .fifo_level_o(fifo_level), .word_count_o(word_count), .overflow_o(overflow)
  );

  int          n_pass = 0, n_total = 0;
  beat_t       exp_q[$];
  logic [7:0]  cur[$];
  int          model_wc = 0;
  bit          drop_next = 0;
  bit          stalled = 0;
  logic [OW-1:0] prev_data;
  logic        prev_last;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // A closed word is just the current letter list, letter 0 in the low byte.
  function automatic void model_close();
    logic [LW*WL-1:0] w = '0;
    foreach (cur[i]) w[i*LW +: LW] = cur[i];
    cur.delete();
    if (!drop_next) begin
      model_wc++;
      for (int b = 0; b < BEATS; b++) exp_q.push_back('{data: w[b*OW +: OW], last: (b == BEATS-1)});
    end
  endfunction

  task automatic send(input bit dv, input logic [7:0] letter, input bit fl);
    bus.data_in   = dv;
    bus.letter_in = letter;
    bus.flush     = fl;
    if (dv) begin
      if (letter != 8'h00) begin
        cur.push_back(letter);
        if (cur.size() == WL) model_close();
      end else if (cur.size() > 0) begin
        model_close();
      end
    end
    if (fl && cur.size() > 0) model_close();
    @(posedge clk); #1;
    bus.data_in   = 1'b0;
    bus.letter_in = 8'h00;
    bus.flush     = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_drain", bus.out_valid, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_count"}, word_count, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stalled = 0;
    end else if (bus.out_valid) begin
      if (stalled) begin
        chk("stall_data", bus.out_data, prev_data);
        chk("stall_last", bus.out_last, prev_last);
      end
      if (bus.out_ready) begin
        stalled = 0;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got %0h expected none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", bus.out_data, e.data);
          chk("beat_last", bus.out_last, e.last);
        end
      end else begin
        stalled   = 1;
        prev_data = bus.out_data;
        prev_last = bus.out_last;
      end
    end else begin
      stalled = 0;
    end
  end

  initial begin
    int k;
    bit dv, fl;
    logic [7:0] lt;
    bus.data_in = 0; bus.letter_in = 0; bus.flush = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;

    // Delimited word and its latency
    bus.out_ready = 1;
    send(1, 8'h41, 0); send(1, 8'h42, 0); send(1, 8'h43, 0); send(1, 8'h00, 0);
    chk("delim_level_n", fifo_level, 1);
    chk("delim_valid_n", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("delim_valid_n1", bus.out_valid, 1);
    chk("delim_level_n1", fifo_level, 0);
    chk("delim_count", word_count, model_wc);
    drain(100);

    // Full word closes on the 16th letter
    for (int i = 1; i <= WL; i++) send(1, 8'(i), 0);
    chk("full_level", fifo_level, 1);
    drain(100);

    // Empty delimiters ignored; flush closes with the same-cycle letter
    send(1, 8'h00, 0); send(1, 8'h00, 0);
    chk("empty_level", fifo_level, 0);
    send(1, 8'h61, 1);
    chk("flush_count", word_count, model_wc);
    drain(100);

    // Backpressure and overflow
    bus.out_ready = 0;
    for (int i = 0; i < 66; i++) begin
      if (i == 65) begin
        chk("ovf_before", overflow, 0);
        drop_next = 1;
      end
      send(1, 8'(i + 1), 0);
      send(1, 8'h00, 0);
    end
    drop_next = 0;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fifo_level, DEPTH);
    chk("ovf_count", word_count, model_wc);
    drain(1000);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_level_end", fifo_level, 0);

    // Reset mid-beat with words queued
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      send(1, 8'h10 + 8'(i), 0); send(1, 8'h20 + 8'(i), 0); send(1, 8'h00, 0);
    end
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_pre_valid", bus.out_valid, 1);
    bus.out_ready = 1;
    @(posedge clk); #1;
    rst_n = 0;
    bus.out_ready = 0;
    exp_q.delete();
    cur.delete();
    model_wc = 0;
    @(posedge clk); #1;
    check_zero("midrst");
    rst_n = 1;
    send(1, 8'hAA, 0); send(1, 8'hBB, 1);
    drain(100);
    chk("midrst_count", word_count, model_wc);

    // Random traffic, generation throttled so the FIFO can never fill
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = ($urandom % 10) != 0;
      dv = (exp_q.size() < 40 * BEATS) && (($urandom % 4) != 0);
      lt = (($urandom % 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      fl = ($urandom % 12) == 0;
      send(dv, lt, fl);
    end
    send(0, 8'h00, 1);
    drain(2000);
    chk("rand_count", word_count, model_wc[15:0]);
    chk("rand_ovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
